// File: rtl/mac_accumulator.sv
// Signed multiply-accumulate back end: sums a burst of 32-bit products into a
// wide accumulator and emits the 32-bit saturated sum with a beat count.
module mac_accumulator #(
    parameter int ACC_W = 40,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_res,
    output logic             out_sat,
    output logic [CNT_W-1:0] out_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};

    state_t             state_r;
    state_t             state_s;
    logic [ACC_W-1:0]   acc_r;
    logic [ACC_W-1:0]   acc_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_s;
    logic               out_valid_r;
    logic [31:0]        out_res_r;
    logic               out_sat_r;
    logic [CNT_W-1:0]   out_cnt_r;
    logic               in_ready_s;
    logic               accept_s;
    logic               load_out_s;
    logic [ACC_W-1:0]   prod_ext_s;
    logic [ACC_W-1:0]   sum_s;
    logic [CNT_W-1:0]   cnt_inc_s;

    // True when the accumulator value is representable as a signed 32-bit number.
    function automatic logic fits32(input logic [ACC_W-1:0] v);
        logic [ACC_W-32:0] hi;
        hi = v[ACC_W-1:31];
        return (hi == {(ACC_W-31){1'b0}}) || (hi == {(ACC_W-31){1'b1}});
    endfunction

    // Clip the wide sum into the signed 32-bit range.
    function automatic logic [31:0] sat32(input logic [ACC_W-1:0] v);
        logic [31:0] r;
        if (fits32(v)) begin
            r = v[31:0];
        end else if (v[ACC_W-1]) begin
            r = 32'h8000_0000;
        end else begin
            r = 32'h7FFF_FFFF;
        end
        return r;
    endfunction

    assign prod_ext_s = {{(ACC_W-32){in_prod[31]}}, in_prod};
    assign sum_s      = (state_r == ST_IDLE) ? prod_ext_s : (acc_r + prod_ext_s);
    assign cnt_inc_s  = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);
    // clr must block acceptance in the same cycle, so ready is combinational.
    assign in_ready_s = ~clr & ((state_r == ST_IDLE) | (state_r == ST_ACC));
    assign accept_s   = in_valid & in_ready_s;

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_res   = out_res_r;
    assign out_sat   = out_sat_r;
    assign out_cnt   = out_cnt_r;

    // Next-state, accumulator and counter update.
    always_comb begin
        state_s    = state_r;
        acc_s      = acc_r;
        cnt_s      = cnt_r;
        load_out_s = 1'b0;
        if (clr) begin
            state_s = ST_IDLE;
            acc_s   = ACC_ZERO;
            cnt_s   = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        acc_s      = sum_s;
                        cnt_s      = CNT_ONE;
                        load_out_s = in_last;
                        state_s    = in_last ? ST_DONE : ST_ACC;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_ACC: begin
                    if (accept_s) begin
                        acc_s      = sum_s;
                        cnt_s      = cnt_inc_s;
                        load_out_s = in_last;
                        state_s    = in_last ? ST_DONE : ST_ACC;
                    end else begin
                        state_s = ST_ACC;
                    end
                end
                ST_DONE: begin
                    if (out_valid_r & out_ready) begin
                        state_s = ST_IDLE;
                        acc_s   = ACC_ZERO;
                        cnt_s   = {CNT_W{1'b0}};
                    end else begin
                        state_s = ST_DONE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    acc_s   = ACC_ZERO;
                    cnt_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // State, accumulator and beat counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            acc_r   <= ACC_ZERO;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            acc_r   <= acc_s;
            cnt_r   <= cnt_s;
        end
    end

    // Result registers: loaded on the last accepted beat, held until handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_res_r   <= 32'h0000_0000;
            out_sat_r   <= 1'b0;
            out_cnt_r   <= {CNT_W{1'b0}};
        end else if (clr) begin
            out_valid_r <= 1'b0;
        end else if (load_out_s) begin
            out_valid_r <= 1'b1;
            out_res_r   <= sat32(acc_s);
            out_sat_r   <= ~fits32(acc_s);
            out_cnt_r   <= cnt_s;
        end else if (out_valid_r & out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

endmodule
